// File: rtl/lockstep_drv_pkg.sv
// Shared types and opcode helpers for the lockstep program driver.
package lockstep_drv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DUT_RST = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // True for opcodes that occupy the shim's load/store unit.
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/lockstep_issue_lane.sv
// One issue lane: private pc and bubble for a single shim copy.
// A lane only advances on its own transfer, so a stalled copy never
// holds back its siblings.
module lockstep_issue_lane
    import lockstep_drv_pkg::*;
#(
    parameter int LW           = 3,
    parameter int THROTTLE_MEM = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          run_i,
    input  logic [LW-1:0] len_i,
    input  logic [6:0]    opcode_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [LW-1:0] pc_o,
    output logic          fin_next_o
);

    logic [LW-1:0] pc_q, pc_d;
    logic          bubble_q, bubble_d;
    logic          xfer;
    logic [LW-1:0] pc_adv;

    // Valid/transfer decode and next pc/bubble; a bubble never outlives one cycle.
    always_comb begin
        valid_o    = run_i && (pc_q < len_i) && !bubble_q;
        xfer       = valid_o && ready_i;
        pc_adv     = xfer ? (pc_q + LW'(1)) : pc_q;
        fin_next_o = (pc_adv == len_i);
        pc_d       = pc_adv;
        bubble_d   = xfer && (THROTTLE_MEM != 0) && is_mem_op(opcode_i);
        if (clear_i) begin
            pc_d     = '0;
            bubble_d = 1'b0;
        end
    end

    // Lane state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= '0;
            bubble_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            bubble_q <= bubble_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/lockstep_prog_driver.sv
// Lockstep stimulus driver: program ROM, shim reset sequencing, per-copy
// issue lanes and first-divergence capture on the copies' ready outputs.
// Handshake: a channel transfers in a cycle where instr_valid_o[c] and
// instr_ready_i[c] are both 1; valid never depends on ready, and once
// raised it holds with stable data until the transfer.
module lockstep_prog_driver
    import lockstep_drv_pkg::*;
#(
    parameter  int NUM_CH       = 2,
    parameter  int PROG_DEPTH   = 4,
    parameter  int INSTR_W      = 32,
    parameter  int RESET_CYCLES = 3,
    parameter  int THROTTLE_MEM = 1,
    localparam int AW           = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
    localparam int LW           = $clog2(PROG_DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      prog_we_i,
    input  logic [AW-1:0]             prog_addr_i,
    input  logic [INSTR_W-1:0]        prog_data_i,
    input  logic [LW-1:0]             prog_len_i,
    input  logic                      start_i,
    output logic                      dut_rst_no,
    output logic [NUM_CH*INSTR_W-1:0] instr_o,
    output logic [NUM_CH-1:0]         instr_valid_o,
    input  logic [NUM_CH-1:0]         instr_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      diverge_o,
    output logic [15:0]               diverge_cycle_o
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [LW-1:0]      len_q, len_d;
    logic [RCW-1:0]     rcnt_q, rcnt_d;
    logic [15:0]        run_cnt_q, run_cnt_d;
    logic               div_q, div_d;
    logic [15:0]        dcyc_q, dcyc_d;
    logic [INSTR_W-1:0] rom_q [PROG_DEPTH];

    logic               idle_or_done;
    logic               start_ok;
    logic               rom_we;
    logic               in_run;
    logic [LW-1:0]      lane_pc [NUM_CH];
    logic [NUM_CH-1:0]  lane_valid;
    logic [NUM_CH-1:0]  lane_fin;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign start_ok     = start_i && idle_or_done;
    assign rom_we       = prog_we_i && idle_or_done && (int'(prog_addr_i) < PROG_DEPTH);
    assign in_run       = (state_q == RUN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [INSTR_W-1:0] rd_word;
        assign rd_word = rom_q[lane_pc[c][AW-1:0]];

        lockstep_issue_lane #(
            .LW           (LW),
            .THROTTLE_MEM (THROTTLE_MEM)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (start_ok),
            .run_i      (in_run),
            .len_i      (len_q),
            .opcode_i   (rd_word[6:0]),
            .ready_i    (instr_ready_i[c]),
            .valid_o    (lane_valid[c]),
            .pc_o       (lane_pc[c]),
            .fin_next_o (lane_fin[c])
        );
    end

    // Program ROM: written only while idle or done, never cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rom_we) begin
            rom_q[prog_addr_i] <= prog_data_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; RUN ends once every lane's next pc reaches len.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = DUT_RST;
            DUT_RST: if (rcnt_q == RCW'(RESET_CYCLES - 1)) state_d = RUN;
            RUN:     if (&lane_fin) state_d = DONE;
            DONE:    if (start_ok) state_d = DUT_RST;
            default: state_d = IDLE;
        endcase
    end

    // Run bookkeeping: length latch, reset/run counters, divergence capture.
    always_comb begin
        len_d     = len_q;
        rcnt_d    = rcnt_q;
        run_cnt_d = run_cnt_q;
        div_d     = div_q;
        dcyc_d    = dcyc_q;
        if (start_ok) begin
            len_d     = (prog_len_i > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : prog_len_i;
            rcnt_d    = '0;
            run_cnt_d = '0;
            div_d     = 1'b0;
            dcyc_d    = '0;
        end else if (state_q == DUT_RST) begin
            rcnt_d = rcnt_q + RCW'(1);
        end else if (in_run) begin
            if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
            if (!div_q && (|instr_ready_i) && !(&instr_ready_i)) begin
                div_d  = 1'b1;
                dcyc_d = run_cnt_q;
            end
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q     <= '0;
            rcnt_q    <= '0;
            run_cnt_q <= '0;
            div_q     <= 1'b0;
            dcyc_q    <= '0;
        end else begin
            len_q     <= len_d;
            rcnt_q    <= rcnt_d;
            run_cnt_q <= run_cnt_d;
            div_q     <= div_d;
            dcyc_q    <= dcyc_d;
        end
    end

    // FSM outputs and per-channel instruction mux (no path from ready).
    always_comb begin
        dut_rst_no      = (state_q != DUT_RST);
        busy_o          = (state_q == DUT_RST) || in_run;
        done_o          = (state_q == DONE);
        diverge_o       = div_q;
        diverge_cycle_o = dcyc_q;
        instr_valid_o   = lane_valid;
        instr_o         = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_run && (lane_pc[c] < len_q)) begin
                instr_o[c*INSTR_W +: INSTR_W] = rom_q[lane_pc[c][AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_lockstep_prog_driver.sv
// Directed and randomized bench for lockstep_prog_driver. The reference
// model tracks each channel as a pc plus the earliest cycle it may issue
// again, which follows directly from the issue-spacing rules.
module tb_lockstep_prog_driver;

  localparam int NUM_CH       = 2;
  localparam int PROG_DEPTH   = 4;
  localparam int INSTR_W      = 32;
  localparam int RESET_CYCLES = 3;
  localparam int THROTTLE_MEM = 1;
  localparam int AW           = 2;
  localparam int LW           = 3;

  localparam int MODE_ONES = 0;
  localparam int MODE_DIV  = 1;
  localparam int MODE_RAND = 2;
  localparam int MODE_WE   = 3;

  logic                      clk_i = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      prog_we_i = 1'b0;
  logic [AW-1:0]             prog_addr_i = '0;
  logic [INSTR_W-1:0]        prog_data_i = '0;
  logic [LW-1:0]             prog_len_i = '0;
  logic                      start_i = 1'b0;
  logic                      dut_rst_no;
  logic [NUM_CH*INSTR_W-1:0] instr_o;
  logic [NUM_CH-1:0]         instr_valid_o;
  logic [NUM_CH-1:0]         instr_ready_i = '0;
  logic                      busy_o;
  logic                      done_o;
  logic                      diverge_o;
  logic [15:0]               diverge_cycle_o;

  int checks   = 0;
  int failures = 0;
  logic [INSTR_W-1:0] rom_m [PROG_DEPTH];

  lockstep_prog_driver #(
    .NUM_CH       (NUM_CH),
    .PROG_DEPTH   (PROG_DEPTH),
    .INSTR_W      (INSTR_W),
    .RESET_CYCLES (RESET_CYCLES),
    .THROTTLE_MEM (THROTTLE_MEM)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .prog_we_i       (prog_we_i),
    .prog_addr_i     (prog_addr_i),
    .prog_data_i     (prog_data_i),
    .prog_len_i      (prog_len_i),
    .start_i         (start_i),
    .dut_rst_no      (dut_rst_no),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .diverge_o       (diverge_o),
    .diverge_cycle_o (diverge_cycle_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk_instr(input int kind);
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case (kind)
      1:       opc = 7'b0000011;
      2:       opc = 7'b0100011;
      default: opc = 7'b0010011;
    endcase
    return {r[24:0], opc};
  endfunction

  function automatic bit is_mem(input logic [INSTR_W-1:0] ins);
    return (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
  endfunction

  task automatic load_rom(input int k0, input int k1, input int k2, input int k3);
    int kinds[4];
    kinds = '{k0, k1, k2, k3};
    for (int a = 0; a < PROG_DEPTH; a++) begin
      prog_we_i   = 1'b1;
      prog_addr_i = AW'(a);
      prog_data_i = mk_instr(kinds[a]);
      rom_m[a]    = prog_data_i;
      step();
    end
    prog_we_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_no"}, 64'(dut_rst_no), 64'd1);
    check({tag, "_valid"}, 64'(instr_valid_o), 64'd0);
    check({tag, "_instr"}, 64'(instr_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_div"}, 64'(diverge_o), 64'd0);
    check({tag, "_dcyc"}, 64'(diverge_cycle_o), 64'd0);
  endtask

  // Starts a run from IDLE/DONE and checks every cycle against the model.
  // run_cycles counts cycles the DUT itself showed as RUN.
  task automatic do_run(input int len_in, input int mode, input bit mid_reset,
                        output int run_cycles);
    int len;
    int pc[NUM_CH];
    int next_ok[NUM_CH];
    int obs_x[NUM_CH];
    bit div;
    int dcyc;
    bit finished;
    bit ev;
    logic [INSTR_W-1:0] ei;
    logic [NUM_CH-1:0] rdy;
    int a;

    run_cycles = 0;
    len = (len_in > PROG_DEPTH) ? PROG_DEPTH : len_in;
    for (int c = 0; c < NUM_CH; c++) begin
      pc[c] = 0;
      next_ok[c] = 0;
      obs_x[c] = 0;
    end
    div = 1'b0;
    dcyc = 0;
    finished = 1'b0;

    prog_len_i = LW'(len_in);
    start_i = 1'b1;
    if (mode == MODE_RAND) begin
      a = $urandom_range(0, PROG_DEPTH - 1);
      prog_we_i = 1'b1;
      prog_addr_i = AW'(a);
      prog_data_i = mk_instr($urandom_range(0, 2));
      rom_m[a] = prog_data_i;
    end
    step();
    start_i = 1'b0;
    prog_we_i = 1'b0;

    for (int r = 0; r < RESET_CYCLES; r++) begin
      check("dutrst_rst_no", 64'(dut_rst_no), 64'd0);
      check("dutrst_busy", 64'(busy_o), 64'd1);
      check("dutrst_done", 64'(done_o), 64'd0);
      check("dutrst_valid", 64'(instr_valid_o), 64'd0);
      check("dutrst_div", 64'(diverge_o), 64'd0);
      if (mode == MODE_RAND) begin
        start_i = 1'($urandom_range(0, 1));
        prog_we_i = 1'($urandom_range(0, 1));
        prog_addr_i = AW'($urandom_range(0, PROG_DEPTH - 1));
        prog_data_i = $urandom();
      end
      step();
      start_i = 1'b0;
      prog_we_i = 1'b0;
    end

    for (int k = 0; k < 200 && !finished; k++) begin
      check("run_rst_no", 64'(dut_rst_no), 64'd1);
      check("run_busy", 64'(busy_o), 64'd1);
      check("run_done", 64'(done_o), 64'd0);
      check("run_div", 64'(diverge_o), 64'(div));
      check("run_dcyc", 64'(diverge_cycle_o), 64'(dcyc));
      for (int c = 0; c < NUM_CH; c++) begin
        ev = (pc[c] < len) && (k >= next_ok[c]);
        ei = (pc[c] < len) ? rom_m[pc[c]] : '0;
        check($sformatf("run_valid_ch%0d_k%0d", c, k), 64'(instr_valid_o[c]), 64'(ev));
        check($sformatf("run_instr_ch%0d_k%0d", c, k), 64'(instr_o[c*INSTR_W +: INSTR_W]), 64'(ei));
      end

      case (mode)
        MODE_DIV:  rdy = (k == 2) ? 2'b01 : 2'b11;
        MODE_RAND: rdy = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
        default:   rdy = '1;
      endcase

      if (mid_reset && k == 1) begin
        instr_ready_i = rdy;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_outputs("midrst");
        return;
      end

      if (mode == MODE_RAND) begin
        start_i = 1'($urandom_range(0, 1));
        prog_we_i = 1'($urandom_range(0, 1));
        prog_addr_i = AW'($urandom_range(0, PROG_DEPTH - 1));
        prog_data_i = $urandom();
      end else if (mode == MODE_WE) begin
        prog_we_i = 1'b1;
        prog_addr_i = AW'(k % PROG_DEPTH);
        prog_data_i = ~rom_m[k % PROG_DEPTH];
      end
      instr_ready_i = rdy;

      for (int c = 0; c < NUM_CH; c++) begin
        if (instr_valid_o[c] && rdy[c]) obs_x[c]++;
        ev = (pc[c] < len) && (k >= next_ok[c]);
        if (ev && rdy[c]) begin
          next_ok[c] = (THROTTLE_MEM != 0 && is_mem(rom_m[pc[c]])) ? k + 2 : k + 1;
          pc[c]++;
        end
      end
      if (!div && rdy != '0 && rdy != '1) begin
        div = 1'b1;
        dcyc = k;
      end
      if (dut_rst_no && busy_o) run_cycles++;

      step();
      start_i = 1'b0;
      prog_we_i = 1'b0;
      finished = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (pc[c] != len) finished = 1'b0;
    end

    instr_ready_i = '0;
    check("run_finished_in_budget", 64'(finished), 64'd1);
    check("end_done", 64'(done_o), 64'd1);
    check("end_busy", 64'(busy_o), 64'd0);
    check("end_rst_no", 64'(dut_rst_no), 64'd1);
    check("end_valid", 64'(instr_valid_o), 64'd0);
    check("end_instr", 64'(instr_o), 64'd0);
    check("end_div", 64'(diverge_o), 64'(div));
    check("end_dcyc", 64'(diverge_cycle_o), 64'(dcyc));
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("xfer_count_ch%0d", c), 64'(obs_x[c]), 64'(len));
  endtask

  initial begin
    int rc;

    // reset
    rst_i = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    step();
    check("idle_done", 64'(done_o), 64'd0);

    // basic run: four ALU ops, ready tied high
    load_rom(0, 0, 0, 0);
    do_run(4, MODE_ONES, 1'b0, rc);
    check("basic_run_cycles", 64'(rc), 64'd4);

    // throttle: LW, SW, LW, ADDI issue at 0,2,4,6
    load_rom(1, 2, 1, 0);
    do_run(4, MODE_ONES, 1'b0, rc);
    check("throttle_run_cycles", 64'(rc), 64'd7);

    // divergence: ch1 not ready in run cycle 2
    load_rom(0, 0, 0, 0);
    do_run(4, MODE_DIV, 1'b0, rc);
    check("div_run_cycles", 64'(rc), 64'd5);
    check("div_flag_sticky", 64'(diverge_o), 64'd1);
    check("div_cycle", 64'(diverge_cycle_o), 64'd2);

    // restart from DONE clears divergence
    do_run(4, MODE_ONES, 1'b0, rc);
    check("restart_div_clear", 64'(diverge_o), 64'd0);

    // clamp and zero length
    do_run(7, MODE_ONES, 1'b0, rc);
    check("clamp_run_cycles", 64'(rc), 64'd4);
    do_run(0, MODE_ONES, 1'b0, rc);
    check("zero_run_cycles", 64'(rc), 64'd1);

    // writes during RUN are ignored; next run reads the original ROM
    load_rom(2, 0, 1, 0);
    do_run(4, MODE_WE, 1'b0, rc);
    do_run(4, MODE_ONES, 1'b0, rc);

    // mid-run reset, then rerun from pc 0 with the retained ROM
    do_run(4, MODE_ONES, 1'b1, rc);
    do_run(4, MODE_ONES, 1'b0, rc);
    check("after_midrst_run_cycles", 64'(rc), 64'd6);

    // randomized runs
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0)
        load_rom($urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      do_run($urandom_range(0, 7), MODE_RAND, 1'b0, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lockstep_prog_driver.md
# lockstep_prog_driver

Synthesizable stimulus driver for lockstep (two-or-more copy) verification of the `cva6_processor_shim`. It holds a loadable program ROM and sequences the DUT reset. It issues the same instruction stream into NUM_CH shim copies, each with its own PC and load/store throttle, and latches the first cycle on which the copies' `instr_ready` outputs diverge. It replaces ad-hoc per-bench feeder logic and generalises copy count, program depth, instruction width and throttle mode.

## Interface
- NUM_CH, 2, number of shim copies driven (≥2)
- PROG_DEPTH, 4, program ROM entries (≥1)
- INSTR_W, 32, instruction width (≥7)
- RESET_CYCLES, 3, cycles `dut_rst_no` is held low after start (≥1)
- THROTTLE_MEM, 1, 1 = insert one bubble on a channel after it issues a load or store; 0 = no bubbles
- AW = max(1, $clog2(PROG_DEPTH)) and LW = $clog2(PROG_DEPTH+1) are derived widths.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- prog_we_i  in  1  ROM write strobe; honoured only in IDLE or DONE
- prog_addr_i  in  AW  ROM write address
- prog_data_i  in  INSTR_W  ROM write data
- prog_len_i  in  LW  instructions to run; sampled on accepted start; clamped to PROG_DEPTH
- start_i  in  1  start pulse; honoured only in IDLE or DONE
- dut_rst_no  out  1  active-low reset to the shims
- instr_o  out  NUM_CH*INSTR_W  per-channel instruction, channel c at [c*INSTR_W +: INSTR_W]
- instr_valid_o  out  NUM_CH  per-channel valid
- instr_ready_i  in  NUM_CH  per-channel shim `instr_ready_o`
- busy_o  out  1  state is DUT_RST or RUN
- done_o  out  1  state is DONE
- diverge_o  out  1  sticky: ready vectors disagreed during RUN
- diverge_cycle_o  out  16  RUN-cycle index of the first divergence

## Operation
- **States:** IDLE → DUT_RST on start_i; DUT_RST → RUN after RESET_CYCLES cycles; RUN → DONE when every channel pc == len; DONE → DUT_RST on start_i.
- **On accepted start:**
  - len ← min(prog_len_i, PROG_DEPTH).
  - All pcs ← 0, bubbles ← 0.
  - diverge_o ← 0, diverge_cycle_o ← 0, run counter ← 0.
- **dut_rst_no:** 0 exactly in DUT_RST, otherwise 1.
- **Per channel c, in RUN:**
  - instr_valid_o[c] = (pc_c < len) & !bubble_c.
  - instr_o slice c = rom[pc_c] when pc_c < len, else 0.
  - Transfer when valid & instr_ready_i[c]. On transfer, pc_c increments.
  - On transfer, bubble_c ← THROTTLE_MEM & (opcode == 7'b0000011 LOAD or 7'b0100011 STORE). Otherwise bubble_c ← 0.
  - A bubble lasts exactly one cycle regardless of ready.
- **Channel independence:** channels advance independently. A stalled channel does not stall the others.
- **Divergence:** in RUN, if instr_ready_i is neither all-0 nor all-1 and diverge_o is 0, then diverge_o ← 1 and diverge_cycle_o ← current run counter. Later divergences do not overwrite.
- **Run counter:** 16-bit. Increments every RUN cycle and saturates at 16'hFFFF.
- **ROM writes:**
  - Written in IDLE or DONE, ignored elsewhere.
  - A write in the same cycle as an accepted start is performed, and is visible from the first RUN cycle.
  - ROM contents are not cleared by rst_i.
- **len = 0:** RUN lasts one cycle with all valids 0, then DONE.
- **rst_i:** rst_i forces IDLE regardless of state. Resulting output values:
  - dut_rst_no = 1, instr_valid_o = 0, instr_o = 0.
  - busy_o = 0, done_o = 0.
  - diverge_o = 0, diverge_cycle_o = 0.
  - All pcs and bubbles = 0.

## Timing
- All state is registered. instr_o and instr_valid_o are combinational from registered pc, bubble, state and ROM; there is no path from instr_ready_i.
- **start_i at cycle t:**
  - State is DUT_RST from t+1 through t+RESET_CYCLES, so dut_rst_no = 0 for exactly RESET_CYCLES cycles.
  - First RUN cycle is t+RESET_CYCLES+1.
- Minimum issue spacing per channel:
  - 1 cycle for ALU instructions.
  - 2 cycles after LOAD/STORE when THROTTLE_MEM = 1.
- done_o rises the cycle after the last transfer on the slowest channel.
- start_i and prog_we_i in DUT_RST or RUN have no effect.

## Structure
- Package `lockstep_drv_pkg` contains:
  - state enum {IDLE, DUT_RST, RUN, DONE};
  - OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
  - the function is_mem_op(opcode).
- Sub-module `lockstep_issue_lane` is instantiated NUM_CH times via generate.
  - Each lane holds pc and bubble.
  - Each lane computes valid and the transfer, and outputs pc for the shared ROM read mux.
- The top level holds the FSM, ROM, reset counter, run counter and divergence logic.

## Test plan
- **Basic run.** NUM_CH=2; ROM = {ADDI, ADDI, ADDI, ADDI}; len=4; ready tied 1.
  - Expect dut_rst_no low 3 cycles, then 4 consecutive transfers per channel.
  - Expect done_o 1 in the 5th RUN cycle; diverge_o = 0.
- **Throttle.** ROM = {LW, SW, LW, ADDI}; ready 1; THROTTLE_MEM=1.
  - Expect transfers in RUN cycles 0, 2, 4, 6 and done in cycle 7.
  - With THROTTLE_MEM=0, expect transfers in cycles 0–3.
- **Divergence.** ch1 ready drops to 0 at RUN cycle 2 only.
  - Expect diverge_o = 1 and diverge_cycle_o = 2, and both stay set.
  - ch0 finishes one cycle before ch1.
- **Clamp and zero length.**
  - prog_len_i = 7 with PROG_DEPTH=4 → exactly 4 transfers.
  - prog_len_i = 0 → one RUN cycle with valid 0, then DONE.
- **Write/start gating.** prog_we_i during RUN leaves the ROM unchanged. start_i in DONE restarts the run with diverge_o cleared.
- **Mid-run reset.** rst_i in RUN cycle 1 → next cycle IDLE with all outputs at reset values. Then start_i reruns from pc 0 with the retained ROM.
